countdown_timer_core: RTL and testbench
=======================================

Name: countdown_timer_core

Overview:
Settable countdown timer that produces the packed 27-bit time word consumed by the display-mode multiplexer, alongside the 12/24-hour clocks and the stopwatch. The user loads a start time field by field with the add buttons, then starts and pauses the count with toggle. The block counts down in centiseconds and flags expiry. All logic runs on the single system clock, using an internal divider for the centisecond tick.

Parameters:
CLK_HZ, 100_000_000, system clock frequency
TICK_HZ, 100, countdown resolution (centisecond tick rate); divider terminal count = CLK_HZ/TICK_HZ - 1
MAX_HR, 23, largest settable hours value; the hours field wraps modulo MAX_HR+1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
toggle  input  1  debounced single-cycle pulse; start/pause/acknowledge
add_one  input  1  debounced single-cycle pulse; +1 to the selected field
add_ten  input  1  debounced single-cycle pulse; +10 to the selected field
ms_sw  input  1  select the centisecond field
sec_sw  input  1  select the seconds field
min_sw  input  1  select the minutes field
hr_sw  input  1  select the hours field
out_time  output  27  packed time: [26:22] hr, [21:16] min, [15:10] sec, [9:3] cs (0-99), [2:0] always 0
running  output  1  high in RUN
done  output  1  high in DONE

Behaviour:
Interface: one clock; reset is asynchronous and active-low. Ports are named clk and reset.
Reset (reset=0, takes effect immediately):
- out_time=0, running=0, done=0, state=SET, divider=0.
All outputs are registered. out_time updates on the clock edge after the causing event.

States:
- SET: editing is allowed; the divider is held at 0.
- RUN: the divider increments every clk. When it reaches its terminal count, it produces a one-cycle tick and reloads 0.
- PAUSE: the divider and value are held.
- DONE: out_time=0 and done=1.

Transitions:
- SET + toggle: go to RUN if out_time != 0; otherwise stay in SET.
- RUN + toggle: go to PAUSE.
- PAUSE + toggle: go to RUN. The divider resumes from its held value.
- RUN + tick that leaves the value at 0: go to DONE. This takes priority over a simultaneous toggle.
- RUN + tick and toggle in the same cycle, value not reaching 0: the decrement is applied and the state goes to PAUSE.
- DONE + toggle: go to SET with value 0 and done cleared.

Editing (SET only; add pulses are ignored in RUN, PAUSE and DONE):
- Field priority when several switches are high: hr_sw > min_sw > sec_sw > ms_sw. If no switch is high, the pulse is ignored.
- Increment = 1*add_one + 10*add_ten, so both in the same cycle adds 11.
- The result is (field + increment) mod range, with range = 100 for cs, 60 for sec and min, MAX_HR+1 for hr. There is no carry into the neighbouring field.
- Example: sec=55 plus add_ten gives 5.

Decrement (on each tick in RUN), borrow chain:
- If cs>0: cs-1.
- Else if sec>0: sec-1, cs=99.
- Else if min>0: min-1, sec=59, cs=99.
- Else hr-1, min=59, sec=59, cs=99.
- The value never decrements below 0. Zero is detected after the update.

Other rules:
- Switch changes take effect only on an add pulse.
- Reset deasserted mid-count: the block restarts in SET with value 0. There is no resumption.

Test Plan:
(Sim with CLK_HZ=1000, TICK_HZ=100, so a tick every 10 clk.)
1. Reset low, then high. Then sec_sw=1 with add_ten x2 and add_one x3 -> out_time[15:10]=23, all other fields 0, running=0.
2. Set sec=1, toggle -> running=1. After 10 clk out_time shows sec=0, cs=99. After 100 ticks total -> done=1, running=0, out_time=0. Toggle -> SET, done=0.
3. Set min=1, run one tick -> min=0, sec=59, cs=99. Set hr=1, run one tick -> hr=0, min=59, sec=59, cs=99.
4. Wrap: min=58 plus add_ten -> 8. Hours at 23 plus add_one -> 0. All four switches high with add_one -> only hr changes.
5. Run, toggle at divider count 4 -> PAUSE, value held for 50 clk. Toggle -> RUN, next tick arrives 6 clk later. Add pulses during PAUSE -> no change.
6. Toggle from SET with value 0 -> stays in SET. Toggle coincident with the final tick (cs=1) -> DONE. Assert reset mid-RUN -> out_time=0, SET, asynchronously before the next edge.

Source files
------------

// File: rtl/countdown_timer_core.sv
// Settable hr:min:sec:cs countdown timer with an internal centisecond divider.
// Produces the packed 27-bit time word used by the display multiplexer.
module countdown_timer_core #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100,
    parameter int MAX_HR  = 23
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        toggle,
    input  logic        add_one,
    input  logic        add_ten,
    input  logic        ms_sw,
    input  logic        sec_sw,
    input  logic        min_sw,
    input  logic        hr_sw,
    output logic [26:0] out_time,
    output logic        running,
    output logic        done
);
    localparam int DIV_TC = CLK_HZ / TICK_HZ - 1;
    localparam int DIV_W  = (DIV_TC > 0) ? $clog2(DIV_TC + 1) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_TC);

    typedef struct packed {
        logic [4:0] hr;
        logic [5:0] mn;
        logic [5:0] sc;
        logic [6:0] cs;
    } tval_t;

    typedef enum logic [1:0] {S_SET, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t           state;
    tval_t            tv;
    tval_t            tv_add;
    tval_t            tv_dec;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic             dec_zero;
    logic             is_add;
    logic [4:0]       inc;

    function automatic logic [6:0] wrap_add(input logic [6:0] f, input logic [4:0] d,
                                            input int range);
        logic [7:0] s;
        s = {1'b0, f} + {3'b000, d};
        return 7'(int'(s) % range);
    endfunction

    assign out_time = {tv, 3'b000};
    assign tick     = (state == S_RUN) && (div == DIV_LAST);
    assign is_add   = add_one | add_ten;

    // Field edit: highest-priority selected switch only, no carry between fields.
    always_comb begin
        tv_add = tv;
        inc    = (add_one ? 5'd1 : 5'd0) + (add_ten ? 5'd10 : 5'd0);
        if (hr_sw)
            tv_add.hr = 5'(wrap_add({2'b00, tv.hr}, inc, MAX_HR + 1));
        else if (min_sw)
            tv_add.mn = 6'(wrap_add({1'b0, tv.mn}, inc, 60));
        else if (sec_sw)
            tv_add.sc = 6'(wrap_add({1'b0, tv.sc}, inc, 60));
        else if (ms_sw)
            tv_add.cs = wrap_add(tv.cs, inc, 100);
    end

    // Borrow chain; a zero value stays at zero.
    always_comb begin
        tv_dec = tv;
        if (tv.cs != '0) begin
            tv_dec.cs = tv.cs - 7'd1;
        end else if (tv.sc != '0) begin
            tv_dec.sc = tv.sc - 6'd1;
            tv_dec.cs = 7'd99;
        end else if (tv.mn != '0) begin
            tv_dec.mn = tv.mn - 6'd1;
            tv_dec.sc = 6'd59;
            tv_dec.cs = 7'd99;
        end else if (tv.hr != '0) begin
            tv_dec.hr = tv.hr - 5'd1;
            tv_dec.mn = 6'd59;
            tv_dec.sc = 6'd59;
            tv_dec.cs = 7'd99;
        end
        dec_zero = (tv_dec == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_SET;
            tv      <= '0;
            div     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_SET: begin
                    div <= '0;
                    if (toggle) begin
                        if (tv != '0) begin
                            state   <= S_RUN;
                            running <= 1'b1;
                        end
                    end else if (is_add) begin
                        tv <= tv_add;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        tv  <= tv_dec;
                        div <= '0;
                        // Expiry outranks a coincident pause request.
                        if (dec_zero) begin
                            state   <= S_DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else if (toggle) begin
                            state   <= S_PAUSE;
                            running <= 1'b0;
                        end
                    end else if (toggle) begin
                        state   <= S_PAUSE;
                        running <= 1'b0;
                    end else begin
                        div <= div + DIV_W'(1);
                    end
                end
                S_PAUSE: begin
                    if (toggle) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end
                end
                S_DONE: begin
                    tv <= '0;
                    if (toggle) begin
                        state <= S_SET;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_SET;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_countdown_timer_core.sv
// Scoreboard bench for countdown_timer_core with a 10-clock centisecond tick.
module tb_countdown_timer_core;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        toggle = 1'b0;
    logic        add_one = 1'b0;
    logic        add_ten = 1'b0;
    logic        ms_sw = 1'b0;
    logic        sec_sw = 1'b0;
    logic        min_sw = 1'b0;
    logic        hr_sw = 1'b0;
    logic [26:0] out_time;
    logic        running;
    logic        done;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string      tag;
        logic [28:0] val;
    } exp_t;
    exp_t sb[$];

    countdown_timer_core #(.CLK_HZ(1000), .TICK_HZ(100), .MAX_HR(23)) dut (
        .clk(clk), .reset(reset), .toggle(toggle), .add_one(add_one), .add_ten(add_ten),
        .ms_sw(ms_sw), .sec_sw(sec_sw), .min_sw(min_sw), .hr_sw(hr_sw),
        .out_time(out_time), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    // {running, done, hr, min, sec, cs, 3'b0}
    function automatic logic [28:0] pk(input int hr, input int mn, input int sc, input int cs,
                                       input logic r, input logic d);
        return {r, d, 5'(hr), 6'(mn), 6'(sc), 7'(cs), 3'b000};
    endfunction

    task automatic chk(input string tag, input logic [28:0] obs, input logic [28:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got run=%0b done=%0b hr=%0d min=%0d sec=%0d cs=%0d low=%0d, want run=%0b done=%0b hr=%0d min=%0d sec=%0d cs=%0d low=%0d",
                     tag, obs[28], obs[27], obs[26:22], obs[21:16], obs[15:10], obs[9:3], obs[2:0],
                     exp[28], exp[27], exp[26:22], exp[21:16], exp[15:10], exp[9:3], exp[2:0]);
        end
    endtask

    task automatic push(input string tag, input logic [28:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_chk();
        exp_t e;
        if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL scoreboard: got empty queue, want an expected entry");
        end else begin
            e = sb.pop_front();
            chk(e.tag, {running, done, out_time}, e.val);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic t, input logic o, input logic n);
        toggle = t; add_one = o; add_ten = n;
        step();
        toggle = 1'b0; add_one = 1'b0; add_ten = 1'b0;
    endtask

    task automatic act_chk(input string tag, input logic t, input logic o, input logic n,
                           input logic [28:0] exp);
        push(tag, exp);
        pulse(t, o, n);
        pop_chk();
    endtask

    task automatic wait_chk(input string tag, input int cycles, input logic [28:0] exp);
        push(tag, exp);
        repeat (cycles) step();
        pop_chk();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        // Reset state
        #2 reset = 1'b0;
        push("reset", pk(0, 0, 0, 0, 0, 0));
        repeat (2) step();
        pop_chk();
        reset = 1'b1;
        step();

        // Seconds entry 10, 20, 21, 22, 23
        sec_sw = 1'b1;
        for (int i = 1; i <= 2; i++) act_chk("sec_add10", 0, 0, 1, pk(0, 0, 10 * i, 0, 0, 0));
        for (int i = 1; i <= 3; i++) act_chk("sec_add1", 0, 1, 0, pk(0, 0, 20 + i, 0, 0, 0));
        sec_sw = 1'b0;

        // One-second countdown to expiry
        do_reset();
        sec_sw = 1'b1;
        act_chk("set_sec1", 0, 1, 0, pk(0, 0, 1, 0, 0, 0));
        sec_sw = 1'b0;
        act_chk("start", 1, 0, 0, pk(0, 0, 1, 0, 1, 0));
        wait_chk("first_tick", 10, pk(0, 0, 0, 99, 1, 0));
        wait_chk("cs1", 980, pk(0, 0, 0, 1, 1, 0));
        wait_chk("expire", 10, pk(0, 0, 0, 0, 0, 1));
        act_chk("ack_done", 1, 0, 0, pk(0, 0, 0, 0, 0, 0));

        // Borrow from minutes, then from hours
        min_sw = 1'b1;
        act_chk("set_min1", 0, 1, 0, pk(0, 1, 0, 0, 0, 0));
        min_sw = 1'b0;
        act_chk("start_min", 1, 0, 0, pk(0, 1, 0, 0, 1, 0));
        wait_chk("borrow_min", 10, pk(0, 0, 59, 99, 1, 0));
        do_reset();
        hr_sw = 1'b1;
        act_chk("set_hr1", 0, 1, 0, pk(1, 0, 0, 0, 0, 0));
        hr_sw = 1'b0;
        act_chk("start_hr", 1, 0, 0, pk(1, 0, 0, 0, 1, 0));
        wait_chk("borrow_hr", 10, pk(0, 59, 59, 99, 1, 0));

        // Field wrap and switch priority
        do_reset();
        min_sw = 1'b1;
        for (int i = 1; i <= 5; i++) act_chk("min_add10", 0, 0, 1, pk(0, 10 * i, 0, 0, 0, 0));
        for (int i = 1; i <= 8; i++) act_chk("min_add1", 0, 1, 0, pk(0, 50 + i, 0, 0, 0, 0));
        act_chk("min_wrap", 0, 0, 1, pk(0, 8, 0, 0, 0, 0));
        min_sw = 1'b0;
        hr_sw = 1'b1;
        act_chk("hr_add11", 0, 1, 1, pk(11, 8, 0, 0, 0, 0));
        act_chk("hr_add11b", 0, 1, 1, pk(22, 8, 0, 0, 0, 0));
        act_chk("hr_23", 0, 1, 0, pk(23, 8, 0, 0, 0, 0));
        act_chk("hr_wrap", 0, 1, 0, pk(0, 8, 0, 0, 0, 0));
        min_sw = 1'b1; sec_sw = 1'b1; ms_sw = 1'b1;
        act_chk("all_sw", 0, 1, 0, pk(1, 8, 0, 0, 0, 0));
        act_chk("none_sw", 0, 0, 0, pk(1, 8, 0, 0, 0, 0));
        hr_sw = 1'b0; min_sw = 1'b0; sec_sw = 1'b0;
        act_chk("ms_wrap_pre", 0, 1, 1, pk(1, 8, 0, 11, 0, 0));
        ms_sw = 1'b0;
        act_chk("no_sw_add", 0, 1, 0, pk(1, 8, 0, 11, 0, 0));

        // Pause / resume with held divider
        do_reset();
        sec_sw = 1'b1;
        act_chk("set_sec1b", 0, 1, 0, pk(0, 0, 1, 0, 0, 0));
        act_chk("set_sec2", 0, 1, 0, pk(0, 0, 2, 0, 0, 0));
        sec_sw = 1'b0;
        act_chk("run2", 1, 0, 0, pk(0, 0, 2, 0, 1, 0));
        repeat (4) step();
        act_chk("pause", 1, 0, 0, pk(0, 0, 2, 0, 0, 0));
        wait_chk("pause_hold", 50, pk(0, 0, 2, 0, 0, 0));
        sec_sw = 1'b1;
        act_chk("pause_add", 0, 1, 1, pk(0, 0, 2, 0, 0, 0));
        sec_sw = 1'b0;
        act_chk("resume", 1, 0, 0, pk(0, 0, 2, 0, 1, 0));
        wait_chk("resume_5clk", 5, pk(0, 0, 2, 0, 1, 0));
        wait_chk("resume_tick", 1, pk(0, 0, 1, 99, 1, 0));
        repeat (9) step();
        act_chk("tick_and_pause", 1, 0, 0, pk(0, 0, 1, 98, 0, 0));

        // Zero start refused; final tick beats coincident toggle
        do_reset();
        act_chk("start_zero", 1, 0, 0, pk(0, 0, 0, 0, 0, 0));
        ms_sw = 1'b1;
        act_chk("set_cs1", 0, 1, 0, pk(0, 0, 0, 1, 0, 0));
        ms_sw = 1'b0;
        act_chk("run_cs1", 1, 0, 0, pk(0, 0, 0, 1, 1, 0));
        repeat (9) step();
        act_chk("final_tick_toggle", 1, 0, 0, pk(0, 0, 0, 0, 0, 1));
        ms_sw = 1'b1;
        act_chk("done_add", 0, 1, 0, pk(0, 0, 0, 0, 0, 1));
        ms_sw = 1'b0;
        act_chk("done_ack", 1, 0, 0, pk(0, 0, 0, 0, 0, 0));

        // Asynchronous reset mid-run
        sec_sw = 1'b1;
        act_chk("set_sec1c", 0, 1, 0, pk(0, 0, 1, 0, 0, 0));
        sec_sw = 1'b0;
        act_chk("run_rst", 1, 0, 0, pk(0, 0, 1, 0, 1, 0));
        wait_chk("mid_run", 15, pk(0, 0, 0, 99, 1, 0));
        push("async_rst", pk(0, 0, 0, 0, 0, 0));
        #2 reset = 1'b0;
        #1 pop_chk();
        #1 reset = 1'b1;
        step();
        act_chk("after_rst_set", 1, 0, 0, pk(0, 0, 0, 0, 0, 0));

        if (sb.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
